ahb_fifo_delay_ctrl: RTL
========================

AHB_FIFO_DELAY_CTRL -- requirements
Module: ahb_fifo_delay_ctrl

Interface
REQ-001 The block SHALL have one clock, cpu_clk, and a synchronous, active-low reset, cpu_rst_b; all state SHALL update on the rising edge of cpu_clk.
REQ-002 Parameter DEPTH, default 4, SHALL set the number of FIFO entries; legal values are powers of two from 2 to 16.
REQ-003 Parameter DW, default 32, SHALL set the payload data width.
REQ-004 cpu_clk  input  1  clock.
REQ-005 cpu_rst_b  input  1  synchronous active-low reset.
REQ-006 in_vld  input  1  push request.
REQ-007 in_data  input  DW  payload to queue.
REQ-008 in_delay  input  32  hold-off cycles for this entry.
REQ-009 in_rdy  output  1  push accepted when in_vld && in_rdy.
REQ-010 out_vld  output  1  head entry released.
REQ-011 out_data  output  DW  head payload.
REQ-012 out_rdy  input  1  consumer accepts the head entry.
REQ-013 ctrl_flush  input  1  synchronous clear of the FIFO and the FSM.
REQ-014 counter_en  output  1  drives the delay counter enable.
REQ-015 counter_load  output  32  delay value loaded by the counter.
REQ-016 counter_done  input  1  counter at zero (combinational from the counter).
REQ-017 fifo_cnt  output  log2(DEPTH)+1  number of occupied entries.
REQ-018 busy  output  1  high when the FSM is not in IDLE.

Function
REQ-019 The FIFO SHALL store {in_data, in_delay} per entry, using a circular read pointer and a circular write pointer of log2(DEPTH) bits that wrap from DEPTH-1 to 0.
REQ-020 in_rdy SHALL equal (fifo_cnt != DEPTH); a push while full SHALL NOT be accepted, even if a pop occurs in the same cycle.
REQ-021 An accepted push SHALL be visible in fifo_cnt and at the head on the next cycle.
REQ-022 A simultaneous push and pop SHALL leave fifo_cnt unchanged.
REQ-023 counter_load SHALL continuously equal the head entry's delay, and SHALL be 0 when the FIFO is empty.
REQ-024 out_data SHALL continuously equal the head entry's data.
REQ-025 The FSM SHALL have four states: IDLE, LOAD, WAIT and OUT.
REQ-026 IDLE: counter_en=0, out_vld=0; the FSM SHALL go to LOAD when fifo_cnt != 0.
REQ-027 LOAD: counter_en=1 for exactly one cycle, which gives the counter a 0->1 enable edge; the FSM SHALL go to WAIT unconditionally; counter_done SHALL be ignored in this cycle.
REQ-028 WAIT: counter_en=1; the FSM SHALL go to OUT when counter_done=1.
REQ-029 OUT: counter_en=0, out_vld=1; on out_rdy=1 the head SHALL be popped, and the FSM SHALL go to LOAD if the post-pop occupancy is non-zero (including a same-cycle push), otherwise to IDLE.
REQ-030 The FSM SHALL hold counter_en=0 for at least one cycle between consecutive LOAD states, so that every entry produces a fresh enable edge.
REQ-031 Latency: with LOAD in cycle t and head delay L, out_vld SHALL first assert in cycle t+2+L; L=0 gives out_vld at t+2.
REQ-032 out_vld SHALL remain high, with out_data stable, until out_rdy=1.
REQ-033 Delay arithmetic SHALL be 32-bit unsigned; L=32'hFFFF_FFFF SHALL be legal, with no internal truncation.
REQ-034 ctrl_flush=1 SHALL, at the next edge, empty the FIFO, reset both pointers to 0, and return the FSM to IDLE (counter_en=0, out_vld=0); a push in the same cycle SHALL be dropped.
REQ-035 ctrl_flush SHALL take priority over push, pop and all FSM transitions.
REQ-036 busy SHALL be 1 in LOAD, WAIT and OUT.

Reset
REQ-037 When cpu_rst_b=0 at a clock edge, the block SHALL set: fifo_cnt=0, both pointers=0, FSM=IDLE, counter_en=0, out_vld=0, in_rdy=1, busy=0, counter_load=0.
REQ-038 Reset SHALL take priority over ctrl_flush; a reset in mid-WAIT SHALL discard all entries, and no out_vld pulse SHALL follow.
REQ-039 Outputs SHALL be undefined only before the first reset edge; no asynchronous reset path is permitted.

Verification
REQ-040 Single push of data=0xA5, delay=3 into an empty FIFO -> LOAD one cycle later, out_vld exactly 5 cycles after LOAD, out_data=0xA5, fifo_cnt=0 after the pop.
REQ-041 Push of delay=0 -> out_vld 2 cycles after LOAD; counter_en low in OUT; a second entry's LOAD follows the pop with counter_en 1 after a 0.
REQ-042 Four pushes, out_rdy=0 -> fifo_cnt=4, in_rdy=0, a fifth push rejected; out_rdy=1 then pops in order, pointers wrap, data order preserved.
REQ-043 Push and pop in the same OUT cycle with fifo_cnt=1 -> fifo_cnt stays 1, FSM goes directly to LOAD.
REQ-044 Entry with delay=1000; ctrl_flush asserted in WAIT -> next cycle FSM=IDLE, counter_en=0, fifo_cnt=0, no out_vld pulse.
REQ-045 cpu_rst_b pulsed low for one cycle during OUT with out_vld=1 -> next cycle all outputs at their reset values (REQ-037), and a push afterwards completes normally.

Source files
------------

// File: rtl/ahb_fifo_delay_ctrl_if.sv
// rtl/ahb_fifo_delay_ctrl_if.sv - bus bundle for the delayed-release FIFO controller
interface ahb_fifo_delay_ctrl_if #(
    parameter int DW    = 32,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          in_vld;
    logic [DW-1:0] in_data;
    logic [31:0]   in_delay;
    logic          in_rdy;
    logic          out_vld;
    logic [DW-1:0] out_data;
    logic          out_rdy;
    logic          ctrl_flush;
    logic          counter_en;
    logic [31:0]   counter_load;
    logic          counter_done;
    logic [CW-1:0] fifo_cnt;
    logic          busy;

    // Controller side
    modport slave (
        input  in_vld, in_data, in_delay, out_rdy, ctrl_flush, counter_done,
        output in_rdy, out_vld, out_data, counter_en, counter_load, fifo_cnt, busy
    );

    // Producer / consumer / counter side
    modport master (
        output in_vld, in_data, in_delay, out_rdy, ctrl_flush, counter_done,
        input  in_rdy, out_vld, out_data, counter_en, counter_load, fifo_cnt, busy
    );
endinterface

// File: rtl/ahb_fifo_delay_ctrl.sv
// rtl/ahb_fifo_delay_ctrl.sv - FIFO whose entries are released after a per-entry counter delay
module ahb_fifo_delay_ctrl #(
    parameter int DEPTH = 4,
    parameter int DW    = 32
) (
    input  logic                  cpu_clk,
    input  logic                  cpu_rst_b,
    ahb_fifo_delay_ctrl_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_WAIT = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    state_t         state_q, state_d;

    logic [DW-1:0]  data_mem_q  [DEPTH];
    logic [31:0]    delay_mem_q [DEPTH];

    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    logic           full;
    logic           empty;
    logic           push;
    logic           pop;
    logic           counter_en;
    logic           out_vld;

    assign full  = (cnt_q == CW'(DEPTH));
    assign empty = (cnt_q == '0);

    // A full FIFO refuses pushes even when the head leaves this cycle; flush drops both.
    assign push  = bus.in_vld && !full && !bus.ctrl_flush;
    assign pop   = (state_q == S_OUT) && bus.out_rdy && !bus.ctrl_flush;

    // Pointer and occupancy next-state; pointers wrap naturally at AW bits.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (bus.ctrl_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + CW'(1);
                2'b01:   cnt_d = cnt_q - CW'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge cpu_clk) begin
        if (!cpu_rst_b) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Entry storage; contents need no reset because occupancy guards every read.
    always_ff @(posedge cpu_clk) begin
        if (cpu_rst_b && push) begin
            data_mem_q[wr_ptr_q]  <= bus.in_data;
            delay_mem_q[wr_ptr_q] <= bus.in_delay;
        end
    end

    // FSM state register.
    always_ff @(posedge cpu_clk) begin
        if (!cpu_rst_b) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state and Moore outputs; OUT always drops the enable so each LOAD gets a fresh edge.
    always_comb begin
        state_d    = state_q;
        counter_en = 1'b0;
        out_vld    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                counter_en = 1'b1;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                counter_en = 1'b1;
                if (bus.counter_done) begin
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                out_vld = 1'b1;
                if (bus.out_rdy) begin
                    state_d = (cnt_d != '0) ? S_LOAD : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (bus.ctrl_flush) begin
            state_d = S_IDLE;
        end
    end

    assign bus.in_rdy       = !full;
    assign bus.fifo_cnt     = cnt_q;
    assign bus.counter_en   = counter_en;
    assign bus.out_vld      = out_vld;
    assign bus.busy         = (state_q != S_IDLE);
    assign bus.counter_load = empty ? 32'd0 : delay_mem_q[rd_ptr_q];
    assign bus.out_data     = empty ? '0 : data_mem_q[rd_ptr_q];

endmodule
